// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared encodings for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    localparam logic [0:0] HZ_IDLE     = 1'b0;
    localparam logic [0:0] HZ_MUL_BUSY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel_unit
// Description : EX operand forwarding select for one source register.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_src_idx,
    input  logic       i_ex_mem_valid,
    input  logic       i_ex_mem_reg_wr,
    input  logic [4:0] i_ex_mem_dest_idx,
    input  logic       i_mem_wb_valid,
    input  logic       i_mem_wb_reg_wr,
    input  logic [4:0] i_mem_wb_dest_idx,
    output logic [1:0] o_sel
);

    logic w_ex_mem_hit;
    logic w_mem_wb_hit;

    // x0 is hardwired to zero, so a write to it must never be forwarded
    assign w_ex_mem_hit = i_ex_mem_valid & i_ex_mem_reg_wr
                        & (i_ex_mem_dest_idx != 5'd0) & (i_ex_mem_dest_idx == i_src_idx);
    assign w_mem_wb_hit = i_mem_wb_valid & i_mem_wb_reg_wr
                        & (i_mem_wb_dest_idx != 5'd0) & (i_mem_wb_dest_idx == i_src_idx);

    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_mem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_mem_wb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Load-use, branch-flush, forwarding and MUL sequencing control
//               for a 5-stage RV32 pipeline, with a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_id_valid_inst,
    input  logic [4:0]       id_ra_idx,
    input  logic [4:0]       id_rb_idx,
    input  logic             id_uses_ra,
    input  logic             id_uses_rb,
    input  logic             id_ex_valid_inst,
    input  logic [4:0]       id_ex_ra_idx,
    input  logic [4:0]       id_ex_rb_idx,
    input  logic [4:0]       id_ex_dest_idx,
    input  logic             id_ex_rd_mem,
    input  logic             id_ex_is_mul,
    input  logic             ex_take_branch,
    input  logic             ex_mem_valid_inst,
    input  logic             ex_mem_reg_wr,
    input  logic [4:0]       ex_mem_dest_idx,
    input  logic             mem_wb_valid_inst,
    input  logic             mem_wb_reg_wr,
    input  logic [4:0]       mem_wb_dest_idx,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mul_busy,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_cycles
);

    import pipe_hazard_ctrl_pkg::*;

    localparam logic             c_mul_multi = (MUL_LAT > 1);
    localparam logic [3:0]       c_cnt_init  = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
    localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic       w_idle;
    logic       w_mul_in_ex;
    logic       w_mul_start;
    logic       w_mul_hold;
    logic       w_mul_done;
    logic       w_lu_raw;
    logic       w_lu;
    logic       w_flush;
    logic       w_stall_front;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    fwd_sel_unit u_fwd_a (
        .i_src_idx         (id_ex_ra_idx),
        .i_ex_mem_valid    (ex_mem_valid_inst),
        .i_ex_mem_reg_wr   (ex_mem_reg_wr),
        .i_ex_mem_dest_idx (ex_mem_dest_idx),
        .i_mem_wb_valid    (mem_wb_valid_inst),
        .i_mem_wb_reg_wr   (mem_wb_reg_wr),
        .i_mem_wb_dest_idx (mem_wb_dest_idx),
        .o_sel             (w_fwd_a)
    );

    fwd_sel_unit u_fwd_b (
        .i_src_idx         (id_ex_rb_idx),
        .i_ex_mem_valid    (ex_mem_valid_inst),
        .i_ex_mem_reg_wr   (ex_mem_reg_wr),
        .i_ex_mem_dest_idx (ex_mem_dest_idx),
        .i_mem_wb_valid    (mem_wb_valid_inst),
        .i_mem_wb_reg_wr   (mem_wb_reg_wr),
        .i_mem_wb_dest_idx (mem_wb_dest_idx),
        .o_sel             (w_fwd_b)
    );

    assign w_idle      = (r_state == HZ_IDLE);
    assign w_mul_in_ex = id_ex_valid_inst & id_ex_is_mul;
    assign w_mul_start = w_idle & w_mul_in_ex & c_mul_multi;
    assign w_mul_hold  = w_mul_start | (~w_idle & (r_cnt != 4'd0));
    // Single-cycle MUL completes straight from IDLE without ever holding
    assign w_mul_done  = (~w_idle & (r_cnt == 4'd0)) | (w_idle & w_mul_in_ex & ~c_mul_multi);

    assign w_lu_raw = if_id_valid_inst & id_ex_valid_inst & id_ex_rd_mem
                    & (id_ex_dest_idx != 5'd0)
                    & ((id_uses_ra & (id_ra_idx == id_ex_dest_idx))
                     | (id_uses_rb & (id_rb_idx == id_ex_dest_idx)));

    // A held ID/EX register must never be bubbled, so MUL holds mask both hazards
    assign w_lu          = w_lu_raw & w_idle & ~w_mul_hold;
    assign w_flush       = ex_take_branch & ~w_mul_hold;
    assign w_stall_front = w_mul_hold | (w_lu & ~w_flush);

    assign stall_pc      = ~rst & w_stall_front;
    assign stall_if_id   = ~rst & w_stall_front;
    assign stall_id_ex   = ~rst & w_mul_hold;
    assign bubble_ex_mem = ~rst & w_mul_hold;
    assign flush_if_id   = ~rst & w_flush;
    assign bubble_id_ex  = ~rst & ~w_mul_hold & (w_flush | w_lu);
    assign mul_busy      = ~rst & ~w_idle;
    assign mul_done      = ~rst & w_mul_done;
    assign fwd_a_sel     = rst ? FWD_RF : w_fwd_a;
    assign fwd_b_sel     = rst ? FWD_RF : w_fwd_b;
    assign stall_cycles  = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= HZ_IDLE;
            r_cnt          <= 4'd0;
            r_stall_cycles <= '0;
        end else begin
            if (w_idle) begin
                if (w_mul_start) begin
                    r_state <= HZ_MUL_BUSY;
                    r_cnt   <= c_cnt_init;
                end
            end else if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_state <= HZ_IDLE;
            end

            if (w_stall_front && (r_stall_cycles != c_cnt_max)) begin
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            end
        end
    end

    // A branch cannot resolve while the MUL occupies EX
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_mul_hold && ex_take_branch));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and random checks of pipe_hazard_ctrl against a
//               cycle-level reference model (MUL_LAT=4/CNT_W=4 and MUL_LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_id_valid_inst, id_uses_ra, id_uses_rb;
    logic [4:0] id_ra_idx, id_rb_idx;
    logic       id_ex_valid_inst, id_ex_rd_mem, id_ex_is_mul, ex_take_branch;
    logic [4:0] id_ex_ra_idx, id_ex_rb_idx, id_ex_dest_idx;
    logic       ex_mem_valid_inst, ex_mem_reg_wr, mem_wb_valid_inst, mem_wb_reg_wr;
    logic [4:0] ex_mem_dest_idx, mem_wb_dest_idx;

    logic        spc4, sif4, sie4, fif4, bie4, bem4, busy4, done4;
    logic [1:0]  fa4, fb4;
    logic [3:0]  cyc4;
    logic        spc1, sif1, sie1, fif1, bie1, bem1, busy1, done1;
    logic [1:0]  fa1, fb1;
    logic [31:0] cyc1;

    int     vectors     = 0;
    int     miscompares = 0;
    string  phase       = "init";
    int     lat  [2]    = '{4, 1};
    longint cmax [2]    = '{15, 64'hFFFF_FFFF};
    int     age  [2]    = '{0, 0};
    longint cnt  [2]    = '{0, 0};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .if_id_valid_inst(if_id_valid_inst),
        .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_ex_valid_inst(id_ex_valid_inst), .id_ex_ra_idx(id_ex_ra_idx), .id_ex_rb_idx(id_ex_rb_idx),
        .id_ex_dest_idx(id_ex_dest_idx), .id_ex_rd_mem(id_ex_rd_mem), .id_ex_is_mul(id_ex_is_mul),
        .ex_take_branch(ex_take_branch), .ex_mem_valid_inst(ex_mem_valid_inst), .ex_mem_reg_wr(ex_mem_reg_wr),
        .ex_mem_dest_idx(ex_mem_dest_idx), .mem_wb_valid_inst(mem_wb_valid_inst), .mem_wb_reg_wr(mem_wb_reg_wr),
        .mem_wb_dest_idx(mem_wb_dest_idx), .stall_pc(spc4), .stall_if_id(sif4), .stall_id_ex(sie4),
        .flush_if_id(fif4), .bubble_id_ex(bie4), .bubble_ex_mem(bem4), .fwd_a_sel(fa4), .fwd_b_sel(fb4),
        .mul_busy(busy4), .mul_done(done4), .stall_cycles(cyc4)
    );

    pipe_hazard_ctrl #(.MUL_LAT(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .if_id_valid_inst(if_id_valid_inst),
        .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_ex_valid_inst(id_ex_valid_inst), .id_ex_ra_idx(id_ex_ra_idx), .id_ex_rb_idx(id_ex_rb_idx),
        .id_ex_dest_idx(id_ex_dest_idx), .id_ex_rd_mem(id_ex_rd_mem), .id_ex_is_mul(id_ex_is_mul),
        .ex_take_branch(ex_take_branch), .ex_mem_valid_inst(ex_mem_valid_inst), .ex_mem_reg_wr(ex_mem_reg_wr),
        .ex_mem_dest_idx(ex_mem_dest_idx), .mem_wb_valid_inst(mem_wb_valid_inst), .mem_wb_reg_wr(mem_wb_reg_wr),
        .mem_wb_dest_idx(mem_wb_dest_idx), .stall_pc(spc1), .stall_if_id(sif1), .stall_id_ex(sie1),
        .flush_if_id(fif1), .bubble_id_ex(bie1), .bubble_ex_mem(bem1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
        .mul_busy(busy1), .mul_done(done1), .stall_cycles(cyc1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] idx);
        if (ex_mem_valid_inst && ex_mem_reg_wr && ex_mem_dest_idx != 0 && ex_mem_dest_idx == idx) return 2'b01;
        if (mem_wb_valid_inst && mem_wb_reg_wr && mem_wb_dest_idx != 0 && mem_wb_dest_idx == idx) return 2'b10;
        return 2'b00;
    endfunction

    // Model: age = cycles the current MUL has already spent in EX (0 = none in progress)
    task automatic tick();
        int     k, nage[2];
        longint ncnt[2];
        bit     hold, done, busy, lu, fl, spc;
        logic [7:0] e_ctrl, o_ctrl;
        logic [1:0] e_fa, e_fb;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (age[i] > 0) k = age[i] + 1;
            else            k = (id_ex_valid_inst && id_ex_is_mul) ? 1 : 0;
            hold = (k > 0) && (k < lat[i]);
            done = (k > 0) && (k == lat[i]);
            busy = (age[i] > 0);
            lu   = (age[i] == 0) && !hold && if_id_valid_inst && id_ex_valid_inst && id_ex_rd_mem
                   && id_ex_dest_idx != 0
                   && ((id_uses_ra && id_ra_idx == id_ex_dest_idx) || (id_uses_rb && id_rb_idx == id_ex_dest_idx));
            fl   = ex_take_branch && !hold;
            spc  = hold || (lu && !fl);
            if (rst) begin
                e_ctrl = 8'h00; e_fa = 2'b00; e_fb = 2'b00;
                nage[i] = 0; ncnt[i] = 0;
            end else begin
                e_ctrl = {spc, spc, hold, fl, !hold && (fl || lu), hold, busy, done};
                e_fa = fwd_ref(id_ex_ra_idx);
                e_fb = fwd_ref(id_ex_rb_idx);
                nage[i] = hold ? k : 0;
                ncnt[i] = (spc && cnt[i] < cmax[i]) ? cnt[i] + 1 : cnt[i];
            end
            o_ctrl = (i == 0) ? {spc4, sif4, sie4, fif4, bie4, bem4, busy4, done4}
                              : {spc1, sif1, sie1, fif1, bie1, bem1, busy1, done1};
            chk($sformatf("%s L%0d ctrl{spc,sif,sie,fif,bie,bem,busy,done}", phase, lat[i]), o_ctrl, e_ctrl);
            chk($sformatf("%s L%0d fwd_a", phase, lat[i]), (i == 0) ? fa4 : fa1, e_fa);
            chk($sformatf("%s L%0d fwd_b", phase, lat[i]), (i == 0) ? fb4 : fb1, e_fb);
            chk($sformatf("%s L%0d stall_cycles", phase, lat[i]),
                (i == 0) ? {60'd0, cyc4} : {32'd0, cyc1}, 64'(cnt[i]));
        end
        @(posedge clk);
        age = nage;
        cnt = ncnt;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_id_valid_inst = 0; id_ra_idx = 0; id_rb_idx = 0; id_uses_ra = 0; id_uses_rb = 0;
        id_ex_valid_inst = 0; id_ex_ra_idx = 0; id_ex_rb_idx = 0; id_ex_dest_idx = 0;
        id_ex_rd_mem = 0; id_ex_is_mul = 0; ex_take_branch = 0;
        ex_mem_valid_inst = 0; ex_mem_reg_wr = 0; ex_mem_dest_idx = 0;
        mem_wb_valid_inst = 0; mem_wb_reg_wr = 0; mem_wb_dest_idx = 0;
    endtask

    task automatic setup_load_use();
        clear_inputs();
        if_id_valid_inst = 1; id_ra_idx = 3; id_uses_ra = 1; id_rb_idx = 1; id_uses_rb = 1;
        id_ex_valid_inst = 1; id_ex_rd_mem = 1; id_ex_dest_idx = 3;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        phase = "reset";
        setup_load_use();
        tick();
        rst = 0;

        phase = "fwd";
        clear_inputs();
        id_ex_valid_inst = 1; id_ex_ra_idx = 5; id_ex_rb_idx = 5;
        ex_mem_valid_inst = 1; ex_mem_reg_wr = 1; ex_mem_dest_idx = 5;
        mem_wb_valid_inst = 1; mem_wb_reg_wr = 1; mem_wb_dest_idx = 5;
        #1 chk("fwd exmem priority", fa4, 2'b01);
        tick();
        ex_mem_dest_idx = 0; mem_wb_dest_idx = 0;
        #1 chk("fwd x0 never", fa4, 2'b00);
        tick();

        phase = "loaduse";
        setup_load_use();
        #1 chk("lu stall_pc", spc4, 1'b1);
        tick();
        clear_inputs();
        id_ex_valid_inst = 1; id_ex_ra_idx = 3; id_ex_dest_idx = 4;
        mem_wb_valid_inst = 1; mem_wb_reg_wr = 1; mem_wb_dest_idx = 3;
        #1 chk("lu release stall_pc", spc4, 1'b0);
        chk("lu fwd_a memwb", fa4, 2'b10);
        chk("lu stall_cycles", cyc4, 4'd1);
        tick();

        phase = "branch";
        setup_load_use();
        ex_take_branch = 1;
        #1 chk("br flush", {fif4, bie4, spc4}, 3'b110);
        tick();

        phase = "mul";
        clear_inputs();
        id_ex_valid_inst = 1; id_ex_is_mul = 1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 4; c++) begin
                #1 chk($sformatf("mul r%0d c%0d {sie,bem,busy,done}", r, c), {sie4, bem4, busy4, done4},
                       {c < 4, c < 4, c > 1, c == 4});
                chk($sformatf("mul1 r%0d c%0d {sie,done}", r, c), {sie1, done1}, 2'b01);
                tick();
            end
        end
        clear_inputs();
        tick();

        phase = "rstmid";
        id_ex_valid_inst = 1; id_ex_is_mul = 1;
        tick();
        tick();
        rst = 1;
        #1 chk("rstmid outputs", {spc4, sie4, bem4, busy4, done4}, 5'b0);
        tick();
        rst = 0;
        clear_inputs();
        #1 chk("rstmid after {busy,done,cnt}", {busy4, done4, cyc4}, 6'b0);
        tick();

        phase = "sat";
        setup_load_use();
        repeat (20) tick();
        #1 chk("sat stall_cycles", cyc4, 4'd15);
        chk("sat stall_cycles 32b", cyc1, 32'd20);

        phase = "random";
        for (int n = 0; n < 400; n++) begin
            bit pred_hold;
            rst               = ($urandom_range(0, 39) == 0);
            if_id_valid_inst  = $urandom_range(0, 3) != 0;
            id_ra_idx         = 5'($urandom_range(0, 3));
            id_rb_idx         = 5'($urandom_range(0, 3));
            id_uses_ra        = $urandom_range(0, 1) != 0;
            id_uses_rb        = $urandom_range(0, 1) != 0;
            id_ex_valid_inst  = $urandom_range(0, 3) != 0;
            id_ex_ra_idx      = 5'($urandom_range(0, 3));
            id_ex_rb_idx      = 5'($urandom_range(0, 3));
            id_ex_dest_idx    = 5'($urandom_range(0, 3));
            id_ex_rd_mem      = $urandom_range(0, 2) == 0;
            id_ex_is_mul      = $urandom_range(0, 4) == 0;
            ex_take_branch    = $urandom_range(0, 5) == 0;
            ex_mem_valid_inst = $urandom_range(0, 1) != 0;
            ex_mem_reg_wr     = $urandom_range(0, 3) != 0;
            ex_mem_dest_idx   = 5'($urandom_range(0, 3));
            mem_wb_valid_inst = $urandom_range(0, 1) != 0;
            mem_wb_reg_wr     = $urandom_range(0, 3) != 0;
            mem_wb_dest_idx   = 5'($urandom_range(0, 3));
            if (age[0] > 0) begin
                id_ex_valid_inst = 1;
                id_ex_is_mul     = 1;
            end
            pred_hold = (age[0] > 0) ? (age[0] + 1 < lat[0]) : (id_ex_valid_inst && id_ex_is_mul);
            if (pred_hold) ex_take_branch = 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
